// File: rtl/status_led_pwm.sv
// Status LED dimmer: 16-step PWM per channel, with optional per-channel fading
// toward the target brightness when STATUS_LED_FADE_EN is defined.
module status_led_pwm #(
  parameter int unsigned PWM_PRESCALE = 16,
  parameter int unsigned FADE_DIV     = 4096
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic [7:0] ledsIn,
  input  logic [3:0] brightness,
  input  logic       enable,
  output logic [7:0] ledsOut,
  output logic       fadeBusy
);

  generate
    if (PWM_PRESCALE < 1 || PWM_PRESCALE > 65535) begin : g_bad_prescale
      $error("PWM_PRESCALE out of range 1..65535");
    end
    if (FADE_DIV < 1 || FADE_DIV > 65535) begin : g_bad_fade_div
      $error("FADE_DIV out of range 1..65535");
    end
  endgenerate

  localparam logic [15:0] P_LAST = 16'(PWM_PRESCALE - 1);

  logic [15:0]     pCnt_reg, pCnt_next;
  logic [3:0]      pwmCnt_reg, pwmCnt_next;
  logic            pwmTick;
  logic [7:0][3:0] level_reg, level_next;
  logic [7:0][3:0] target;
  logic [7:0]      ledsOut_reg, ledsOut_next;
  logic            fadeBusy_reg, fadeBusy_next;

  always_comb begin
    pwmTick     = (pCnt_reg == P_LAST);
    pCnt_next   = pwmTick ? 16'd0 : pCnt_reg + 16'd1;
    pwmCnt_next = pwmCnt_reg + {3'd0, pwmTick};
    if (!enable) begin
      pCnt_next   = 16'd0;
      pwmCnt_next = 4'd0;
    end
  end

`ifdef STATUS_LED_FADE_EN
  localparam logic [15:0] F_LAST = 16'(FADE_DIV - 1);

  logic [15:0] fCnt_reg, fCnt_next;
  logic        fadeTick;
  logic [7:0]  busy_vec;

  always_comb begin
    fadeTick  = (fCnt_reg == F_LAST);
    fCnt_next = fadeTick ? 16'd0 : fCnt_reg + 16'd1;
    if (!enable) begin
      fCnt_next = 16'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      fCnt_reg <= 16'd0;
    end else begin
      fCnt_reg <= fCnt_next;
    end
  end

  assign fadeBusy_next = |busy_vec;
`else
  assign fadeBusy_next = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chan
      logic [3:0] lvl_next;
      logic       drive_next;

      assign target[gi] = ledsIn[gi] ? brightness : 4'd0;

      always_comb begin
        lvl_next = level_reg[gi];
`ifdef STATUS_LED_FADE_EN
        // One step per fade tick from wherever the level currently is, so a
        // target change mid-fade simply reverses direction without overshoot.
        if (fadeTick) begin
          if (level_reg[gi] < target[gi]) begin
            lvl_next = level_reg[gi] + 4'd1;
          end else if (level_reg[gi] > target[gi]) begin
            lvl_next = level_reg[gi] - 4'd1;
          end
        end
`else
        lvl_next = target[gi];
`endif
        if (!enable) begin
          lvl_next = 4'd0;
        end
        // Level 15 is forced fully on; otherwise on for `level` of 16 steps.
        drive_next = enable & ((level_reg[gi] == 4'd15) | (level_reg[gi] > pwmCnt_reg));
      end

      assign level_next[gi]   = lvl_next;
      assign ledsOut_next[gi] = drive_next;
`ifdef STATUS_LED_FADE_EN
      assign busy_vec[gi] = (lvl_next != target[gi]);
`endif
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!nReset) begin
      pCnt_reg     <= 16'd0;
      pwmCnt_reg   <= 4'd0;
      level_reg    <= '0;
      ledsOut_reg  <= 8'h00;
      fadeBusy_reg <= 1'b0;
    end else begin
      pCnt_reg     <= pCnt_next;
      pwmCnt_reg   <= pwmCnt_next;
      level_reg    <= level_next;
      ledsOut_reg  <= ledsOut_next;
      fadeBusy_reg <= fadeBusy_next;
    end
  end

  assign ledsOut  = ledsOut_reg;
  assign fadeBusy = fadeBusy_reg;

endmodule

// File: tb/tb_status_led_pwm.sv
// Randomized bench for status_led_pwm with a time-based reference model plus
// directed literal checks for reset, fade-up, duty cycle, reversal and blanking.
module tb_status_led_pwm;
  localparam int P = 2;
  localparam int F = 4;

  logic       clock = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] ledsIn = 8'h00;
  logic [3:0] brightness = 4'd0;
  logic       enable = 1'b0;
  logic [7:0] ledsOut;
  logic       fadeBusy;

  int nChecks = 0;
  int nErrors = 0;

  status_led_pwm #(.PWM_PRESCALE(P), .FADE_DIV(F)) dut (
    .clock(clock), .nReset(nReset), .ledsIn(ledsIn), .brightness(brightness),
    .enable(enable), .ledsOut(ledsOut), .fadeBusy(fadeBusy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t = enabled clocks since the last restart. PWM step and
  // fade ticks follow from t directly; levels move one unit per fade tick.
  int         t = 0;
  int         mlev[8] = '{default: 0};
  logic [7:0] expLeds = 8'h00;
  logic       expBusy = 1'b0;

  always @(posedge clock) begin : model
    int tgt;
    int step;
    logic busy;
    if (!nReset || !enable) begin
      t = 0;
      busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mlev[i] = 0;
        tgt = ledsIn[i] ? int'(brightness) : 0;
        if (tgt != 0) busy = 1'b1;
      end
      expLeds = 8'h00;
`ifdef STATUS_LED_FADE_EN
      expBusy = nReset ? busy : 1'b0;
`else
      expBusy = 1'b0;
`endif
    end else begin
      step = (t / P) % 16;
      busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        expLeds[i] = (mlev[i] == 15) || (mlev[i] > step);
        tgt = ledsIn[i] ? int'(brightness) : 0;
`ifdef STATUS_LED_FADE_EN
        if ((t % F) == F - 1) begin
          if (mlev[i] < tgt) mlev[i] = mlev[i] + 1;
          else if (mlev[i] > tgt) mlev[i] = mlev[i] - 1;
        end
        if (mlev[i] != tgt) busy = 1'b1;
`else
        mlev[i] = tgt;
`endif
      end
      expBusy = busy;
      t++;
    end
  end

  always @(negedge clock) begin : compare
    check("ledsOut", {24'd0, ledsOut}, {24'd0, expLeds});
    check("fadeBusy", {31'd0, fadeBusy}, {31'd0, expBusy});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic restart(input int n);
    nReset = 1'b0;
    tick(n);
    nReset = 1'b1;
  endtask

  initial begin
    int ones;

    // Reset held for 3 clocks with everything requesting full brightness.
    ledsIn = 8'hFF; brightness = 4'd15; enable = 1'b1; nReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_leds", {24'd0, ledsOut}, 32'h00);
      check("rst_busy", {31'd0, fadeBusy}, 32'd0);
    end
    nReset = 1'b1;
    tick(1);
`ifdef STATUS_LED_FADE_EN
    check("busy_after_release", {31'd0, fadeBusy}, 32'd1);
`else
    check("busy_after_release", {31'd0, fadeBusy}, 32'd0);
`endif

    // Fade up channel 0 to 15.
    ledsIn = 8'h01; brightness = 4'd15;
    restart(2);
`ifdef STATUS_LED_FADE_EN
    tick(59);
    check("fadeup_busy_59", {31'd0, fadeBusy}, 32'd1);
    tick(1);
    check("fadeup_busy_60", {31'd0, fadeBusy}, 32'd0);
`else
    tick(60);
`endif
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      ones += int'(ledsOut[0]);
    end
    check("fadeup_const_on", ones, 32);

    // Duty cycle at level 4: 8 of 32 clocks.
    ledsIn = 8'h01; brightness = 4'd4;
    restart(2);
    tick(40);
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      ones += int'(ledsOut[0]);
    end
    check("duty_level4", ones, 8);

    // Reversal from level 10 back down to 0.
    ledsIn = 8'h01; brightness = 4'd15;
    restart(2);
    tick(40);
    ledsIn = 8'h00;
    tick(44);
    check("reverse_busy", {31'd0, fadeBusy}, 32'd0);
    check("reverse_off", {31'd0, ledsOut[0]}, 32'd0);

    // One-clock blanking mid-fade.
    ledsIn = 8'hFF; brightness = 4'd15;
    restart(2);
    tick(30);
    enable = 1'b0;
    tick(1);
    check("blank_leds", {24'd0, ledsOut}, 32'h00);
    enable = 1'b1;
    tick(30);

`ifndef STATUS_LED_FADE_EN
    // Immediate follow without fading.
    ledsIn = 8'h00; brightness = 4'd15;
    restart(2);
    tick(3);
    ledsIn = 8'hAA;
    tick(1);
    check("nofade_leds_1", {24'd0, ledsOut}, 32'h00);
    tick(1);
    check("nofade_leds_2", {24'd0, ledsOut}, 32'hAA);
    check("nofade_busy", {31'd0, fadeBusy}, 32'd0);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) ledsIn = 8'($urandom);
      if ($urandom_range(0, 39) == 0) brightness = 4'($urandom);
      enable = ($urandom_range(0, 99) != 0);
      nReset = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    nReset = 1'b1; enable = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/status_led_pwm.md
STATUS_LED_PWM -- requirements
Module: status_led_pwm

Interface
REQ-001 SHALL provide parameter PWM_PRESCALE, default 16: clock cycles per PWM step; legal range 1..65535.
REQ-002 SHALL provide parameter FADE_DIV, default 4096: clock cycles per fade step; legal range 1..65535.
REQ-003 SHALL provide port clock  input  1: single clock, all logic on its rising edge.
REQ-004 SHALL provide port nReset  input  1: reset, synchronous and active-low.
REQ-005 SHALL provide port ledsIn  input  8: on/off pattern from the status LED module, bit i = LED i.
REQ-006 SHALL provide port brightness  input  4: global target level for lit LEDs, 0..15.
REQ-007 SHALL provide port enable  input  1: 1 = drive LEDs, 0 = blank.
REQ-008 SHALL provide port ledsOut  output  8: PWM-modulated LED drive, registered.
REQ-009 SHALL provide port fadeBusy  output  1: 1 while any channel level differs from its target, registered.

Function
REQ-010 SHALL keep prescaler pCnt counting 0..PWM_PRESCALE-1; pwmTick is asserted on the cycle pCnt = PWM_PRESCALE-1, and pCnt then wraps to 0.
REQ-011 SHALL advance 4-bit pwmCnt by 1 on each pwmTick, wrapping 15->0; PWM period = 16*PWM_PRESCALE clocks.
REQ-012 SHALL keep fade counter fCnt counting 0..FADE_DIV-1 independently of pCnt; fadeTick is asserted on fCnt = FADE_DIV-1, and fCnt then wraps to 0.
REQ-013 SHALL define target[i] = ledsIn[i] ? brightness : 0, sampled each cycle with no input registering.
REQ-014 SHALL hold per-channel 4-bit level[i]; on fadeTick, level[i] steps +1 if below target[i], steps -1 if above, and holds if equal.
REQ-015 SHALL, when the target changes mid-fade, step from the current level toward the new target with no restart or overshoot.
REQ-016 SHALL compute next ledsOut[i] = enable & ((level[i] == 15) | (level[i] > pwmCnt)), registered, giving 1-cycle latency from level/pwmCnt to ledsOut.
REQ-017 SHALL drive level 0 as constant off and level 15 as constant on; level n (1..14) is high for n of 16 PWM steps.
REQ-018 SHALL, while enable = 0, force all level[i] to 0 and clear pCnt, pwmCnt, fCnt and ledsOut to 0 on each clock.
REQ-019 SHALL, on enable rising, restart all counters from 0 and fade channels up from level 0.
REQ-020 SHALL register fadeBusy = OR over i of (level[i] != target[i]), evaluated on post-update values.
REQ-021 SHALL ignore a brightness change that occurs without a fadeTick until the next fadeTick; there is no immediate jump.

Reset
REQ-022 SHALL, on a clock edge with nReset = 0, set pCnt, pwmCnt, fCnt and all level[i] to 0, and set ledsOut = 8'h00 and fadeBusy = 0.
REQ-023 SHALL, if reset is asserted mid-fade or mid-period, abandon that fade or period with no residual state; after release, behaviour is identical to power-up.

Configuration
REQ-024 SHALL compile fading when macro STATUS_LED_FADE_EN is defined, with behaviour as REQ-012/014/015/020/021.
REQ-025 SHALL, without STATUS_LED_FADE_EN, omit fCnt, load level[i] = target[i] on every clock (1 clock to follow) and tie fadeBusy to 0; PWM behaviour is otherwise unchanged.

Verification (PWM_PRESCALE=2, FADE_DIV=4, macro defined unless stated)
REQ-026 SHALL cover reset: hold nReset=0 for 3 clocks with ledsIn=8'hFF, brightness=15, enable=1 -> ledsOut=8'h00 and fadeBusy=0 throughout; fadeBusy=1 on the first clock after release.
REQ-027 SHALL cover fade-up: ledsIn=8'h01, brightness=15 from a reset state -> level[0] reaches 15 after 15 fadeTicks (60 clocks), fadeBusy falls on the following clock, and ledsOut[0] stays constantly 1 thereafter.
REQ-028 SHALL cover duty cycle: level[0] settled at 4 -> ledsOut[0] high for exactly 8 of every 32 clocks (4 PWM steps of 2 clocks each).
REQ-029 SHALL cover reversal: with level[0]=10 rising toward 15, drop ledsIn[0] to 0 -> level goes 10,9,...,0 on successive fadeTicks, with no increment after the change.
REQ-030 SHALL cover blanking: enable=0 for 1 clock mid-fade with ledsIn=8'hFF -> ledsOut=8'h00 on the next clock and all levels 0; after enable=1, the fade restarts from level 0.
REQ-031 SHALL cover the no-macro build: ledsIn changes 8'h00->8'hAA with brightness=15 -> level of bits 1,3,5,7 = 15 after 1 clock, ledsOut=8'hAA on the next clock, and fadeBusy remains 0.
